// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute sequencer: vector geometry,
// sequencer states, and the ALU opcode encoding used by the EX-stage decoder.
package vec_pkg;

  localparam int VLEN_MAX = 8;
  localparam int IDX_W    = $clog2(VLEN_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } vec_state_e;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;

  // Requested element count clamped to the register length.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    return (len > 4'(VLEN_MAX)) ? 4'(VLEN_MAX) : len;
  endfunction

endpackage

// File: rtl/vec_exec_seq_if.sv
// Signals between the execute stage and the vector sequencer.
//
// Handshake: vecStartE is a level valid from EX and stays high for as long
// as the instruction sits in EX. stallPipe is the inverse of ready: while it
// is high EX holds the instruction; the instruction retires on the first
// edge where stallPipe is low. vecWe is a valid with no back-pressure: the
// register file always accepts the write in the cycle it is presented.
interface vec_exec_seq_if;
  import vec_pkg::*;

  logic             vecStartE;
  logic [3:0]       vecLenE;
  logic [3:0]       vecAluCtrlE;
  logic             flushE;
  logic [15:0]      aluResE;
  logic             aluOwnVec;
  logic [3:0]       aluCtrlV;
  logic [IDX_W-1:0] elemIdx;
  logic             stallPipe;
  logic             vecWe;
  logic [IDX_W-1:0] vecWIdx;
  logic [15:0]      vecWData;
  logic             busy;
  logic             done;

  // Pipeline / ALU / register-file side.
  modport master (
    output vecStartE, vecLenE, vecAluCtrlE, flushE, aluResE,
    input  aluOwnVec, aluCtrlV, elemIdx, stallPipe, vecWe, vecWIdx, vecWData,
    input  busy, done
  );

  // Sequencer side.
  modport slave (
    input  vecStartE, vecLenE, vecAluCtrlE, flushE, aluResE,
    output aluOwnVec, aluCtrlV, elemIdx, stallPipe, vecWe, vecWIdx, vecWData,
    output busy, done
  );

endinterface

// File: rtl/vec_elem_counter.sv
// Element index counter. Load starts at index 0 and records the last index
// (len-1); tc flags the last element; clear returns to 0 on a flush.
module vec_elem_counter
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             adv,
  input  logic [3:0]       len,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);

  logic [IDX_W-1:0] last_idx;

  // Index and terminal index registers; len is already clamped to 1..VLEN_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      last_idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (load) begin
      idx      <= '0;
      last_idx <= IDX_W'(len - 4'd1);
    end else if (adv && !tc) begin
      idx <= idx + 1'b1;
    end
  end

  assign tc = (idx == last_idx);

endmodule

// File: rtl/vec_exec_seq.sv
// Vector execute sequencer: takes the shared EX ALU for one element per
// cycle, stalls the scalar pipeline meanwhile, and writes each element
// result back one cycle after the ALU produced it.
module vec_exec_seq
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  vec_exec_seq_if.slave       bus,
  output vec_state_e          state_dbg
);

  vec_state_e       state, state_nxt;
  logic [3:0]       len_eff;
  logic             start_ok;
  logic             run;
  logic             cnt_load, cnt_clear, cnt_adv;
  logic [IDX_W-1:0] cnt_idx;
  logic             cnt_tc;
  logic [3:0]       ctrl_q;
  logic             wb_we;
  logic [IDX_W-1:0] wb_idx;
  logic [15:0]      wb_data;

  assign len_eff  = eff_len(bus.vecLenE);
  assign start_ok = bus.vecStartE && (len_eff != 4'd0) && !bus.flushE;
  assign run      = (state == RUN);

  vec_elem_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .clear (cnt_clear),
    .adv   (cnt_adv),
    .len   (len_eff),
    .idx   (cnt_idx),
    .tc    (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and counter control; LAST never restarts even if start is held.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = RUN;
          cnt_load  = 1'b1;
        end
      end
      RUN: begin
        if (bus.flushE) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_nxt = LAST;
        end else begin
          cnt_adv = 1'b1;
        end
      end
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Opcode latched at acceptance so EX may change underneath the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          ctrl_q <= '0;
    else if (state == IDLE && start_ok) ctrl_q <= bus.vecAluCtrlE;
  end

  // Writeback register: captures each element issued in a non-flushed RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we   <= 1'b0;
      wb_idx  <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= run && !bus.flushE;
      if (run && !bus.flushE) begin
        wb_idx  <= cnt_idx;
        wb_data <= bus.aluResE;
      end
    end
  end

  assign bus.aluOwnVec = run;
  assign bus.aluCtrlV  = ctrl_q;
  assign bus.elemIdx   = run ? cnt_idx : '0;
  // The IDLE term is combinational so EX holds in the start cycle itself;
  // gating with rst keeps the stall low while reset is applied.
  assign bus.stallPipe = run || (state == IDLE && start_ok && rst);
  assign bus.vecWe     = wb_we;
  assign bus.vecWIdx   = wb_idx;
  assign bus.vecWData  = wb_data;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == LAST);
  assign state_dbg     = state;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Directed bench for vec_exec_seq: a small ADD/SUB ALU model feeds the
// sequencer, per-cycle control checks follow the documented timeline, and a
// write monitor compares register-file writes against an expected queue.
module tb_vec_exec_seq;
  import vec_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_exec_seq_if bus();
  vec_state_e     state_dbg;

  vec_exec_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Lane operands: a[i] = 0x1000 + i, b[i] = 0x10 * i.
  localparam logic [15:0] ADD_T [8] = '{16'h1000, 16'h1011, 16'h1022, 16'h1033,
                                        16'h1044, 16'h1055, 16'h1066, 16'h1077};
  localparam logic [15:0] SUB_T [8] = '{16'h1000, 16'h0FF1, 16'h0FE2, 16'h0FD3,
                                        16'h0FC4, 16'h0FB5, 16'h0FA6, 16'h0F97};

  logic [15:0] lane_a, lane_b;

  // Shared ALU model: vector lanes when the sequencer owns it, scalar value otherwise.
  always_comb begin
    lane_a = 16'h1000 + 16'(bus.elemIdx);
    lane_b = 16'(bus.elemIdx) << 4;
    if (!bus.aluOwnVec) begin
      bus.aluResE = 16'h5a5a;
    end else begin
      case (bus.aluCtrlV)
        ALU_ADD: bus.aluResE = lane_a + lane_b;
        ALU_SUB: bus.aluResE = lane_a - lane_b;
        default: bus.aluResE = 16'hbad0;
      endcase
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [IDX_W+15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && bus.vecWe) begin
      if (exp_q.size() == 0) begin
        check_eq("wb_unexpected", 32'(bus.vecWe), 32'd0);
      end else begin
        check_eq("wb_idx_data", 32'({bus.vecWIdx, bus.vecWData}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver: check one cycle's controls at negedge, then move to the next cycle.
  task automatic cyc(input string tag, input int c, input logic st, input logic own,
                     input logic bsy, input logic dn, input logic we, input int eidx,
                     input logic [3:0] eop);
    string t;
    t = $sformatf("%s.c%0d", tag, c);
    @(negedge clk);
    check_eq({t, ".stall"}, 32'(bus.stallPipe), 32'(st));
    check_eq({t, ".own"},   32'(bus.aluOwnVec), 32'(own));
    check_eq({t, ".busy"},  32'(bus.busy),      32'(bsy));
    check_eq({t, ".done"},  32'(bus.done),      32'(dn));
    check_eq({t, ".we"},    32'(bus.vecWe),     32'(we));
    if (own) begin
      check_eq({t, ".eidx"}, 32'(bus.elemIdx),  32'(eidx));
      check_eq({t, ".ctrl"}, 32'(bus.aluCtrlV), 32'(eop));
    end
    @(posedge clk);
    #1;
  endtask

  // One vector operation; flush_c > 0 flushes in that RUN cycle.
  // vecStartE is left high after LAST so the caller decides what follows.
  task automatic run_op(input string tag, input logic [3:0] len, input int exp_l,
                        input logic [3:0] op, input int flush_c);
    int n_wr;
    n_wr = (flush_c > 0) ? flush_c - 1 : exp_l;
    for (int i = 0; i < n_wr; i++)
      exp_q.push_back({IDX_W'(i), (op == ALU_SUB) ? SUB_T[i] : ADD_T[i]});
    bus.vecStartE   = 1'b1;
    bus.vecLenE     = len;
    bus.vecAluCtrlE = op;
    bus.flushE      = 1'b0;
    cyc(tag, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, op);
    for (int c = 1; c <= exp_l; c++) begin
      if (c == flush_c) bus.flushE = 1'b1;
      cyc(tag, c, 1'b1, 1'b1, 1'b1, 1'b0, (c >= 2), c - 1, op);
      if (c == flush_c) begin
        bus.flushE    = 1'b0;
        bus.vecStartE = 1'b0;
        cyc(tag, c + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, op);
        return;
      end
    end
    cyc(tag, exp_l + 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, op);
  endtask

  initial begin
    // Reset state, with a start request already present.
    bus.vecStartE   = 1'b1;
    bus.vecLenE     = 4'd4;
    bus.vecAluCtrlE = ALU_ADD;
    bus.flushE      = 1'b0;
    #12;
    check_eq("rst.stall", 32'(bus.stallPipe), 32'd0);
    check_eq("rst.own",   32'(bus.aluOwnVec), 32'd0);
    check_eq("rst.busy",  32'(bus.busy),      32'd0);
    check_eq("rst.done",  32'(bus.done),      32'd0);
    check_eq("rst.we",    32'(bus.vecWe),     32'd0);
    check_eq("rst.eidx",  32'(bus.elemIdx),   32'd0);
    check_eq("rst.ctrl",  32'(bus.aluCtrlV),  32'd0);
    check_eq("rst.state", 32'(state_dbg),     32'(IDLE));
    bus.vecStartE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Length 4 ADD, start held through LAST, then SUB length 3 at cycle L+2.
    run_op("add4", 4'd4, 4, ALU_ADD, -1);
    run_op("sub3", 4'd3, 3, ALU_SUB, -1);
    bus.vecStartE = 1'b0;
    cyc("idle1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);

    // Zero length is a no-op.
    bus.vecStartE = 1'b1;
    bus.vecLenE   = 4'd0;
    for (int c = 0; c < 3; c++)
      cyc("len0", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);
    bus.vecStartE = 1'b0;

    // Length 12 clamps to 8.
    run_op("len12", 4'd12, 8, ALU_ADD, -1);
    bus.vecStartE = 1'b0;
    cyc("idle2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);

    // Flush at RUN cycle 3 of a length-6 op.
    run_op("flush6", 4'd6, 6, ALU_ADD, 3);

    // Flush in IDLE ignores the start.
    bus.vecStartE = 1'b1;
    bus.vecLenE   = 4'd4;
    bus.flushE    = 1'b1;
    cyc("flush_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);
    bus.vecStartE = 1'b0;
    bus.flushE    = 1'b0;
    cyc("flush_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);

    // Reset in RUN cycle 2 of a length-5 SUB.
    exp_q.push_back({IDX_W'(0), SUB_T[0]});
    bus.vecStartE   = 1'b1;
    bus.vecLenE     = 4'd5;
    bus.vecAluCtrlE = ALU_SUB;
    cyc("rstrun", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_SUB);
    cyc("rstrun", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, ALU_SUB);
    @(negedge clk);
    check_eq("rstrun.c2.own",  32'(bus.aluOwnVec), 32'd1);
    check_eq("rstrun.c2.eidx", 32'(bus.elemIdx),   32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rstrun.async.stall", 32'(bus.stallPipe), 32'd0);
    check_eq("rstrun.async.own",   32'(bus.aluOwnVec), 32'd0);
    check_eq("rstrun.async.busy",  32'(bus.busy),      32'd0);
    check_eq("rstrun.async.done",  32'(bus.done),      32'd0);
    check_eq("rstrun.async.we",    32'(bus.vecWe),     32'd0);
    check_eq("rstrun.async.eidx",  32'(bus.elemIdx),   32'd0);
    check_eq("rstrun.async.widx",  32'(bus.vecWIdx),   32'd0);
    check_eq("rstrun.async.wdata", 32'(bus.vecWData),  32'd0);
    check_eq("rstrun.async.ctrl",  32'(bus.aluCtrlV),  32'd0);
    bus.vecStartE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++)
      cyc("post_rst_idle", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);
    run_op("post_rst", 4'd2, 2, ALU_ADD, -1);
    bus.vecStartE = 1'b0;
    cyc("idle3", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ALU_ADD);

    // Final report
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
